ser_byte_scheduler: RTL and testbench

Round-robin scheduler that shares one 8-bit-to-1-bit serial lane between up to NREQ byte requesters. It accepts one byte per frame through a valid/ready handshake and holds that byte stable for the whole frame. It shifts the byte out LSB-first, one bit per clock, and drives frame markers and the bit index for downstream framing and checking logic. It sits between the byte producers and the serial output pin.

---
 rtl/ser_byte_scheduler.sv | 120 ++++++++++++
 tb/tb_ser_byte_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_byte_scheduler.sv
// Round-robin scheduler sharing one serial lane among NREQ byte requesters, LSB-first.
// Latency: accept in clock T puts bit 0 on ser_out in T+1, bit 7 in T+8; frame period 8+GAP.
// Backpressure: req_ready is a combinational one-hot strobe, high only at accept points.
module ser_byte_scheduler #(
  parameter int NREQ = 4,
  parameter int GAP  = 0,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                ser_out,
  output logic                ser_frame,
  output logic                ser_sof,
  output logic [2:0]          bit_idx,
  output logic [7:0]          ser_byte,
  output logic [IDW-1:0]      grant_id,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  // Last gap clock index; the GAP=0 value is never used because the gap state is unreachable.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit         HAS_GAP  = (GAP > 0);

  state_t          state;
  logic [IDW-1:0]  last_grant;
  logic [3:0]      gap_cnt;

  logic            accept_pt;
  logic            found;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  cand;
  logic [7:0]      pick_data;
  logic            take;
  logic [2:0]      nxt_idx;

  // Accept points: IDLE, bit-7 clock of SHIFT when there is no gap, and the last gap clock.
  always_comb begin
    accept_pt = 1'b0;
    case (state)
      S_IDLE:  accept_pt = 1'b1;
      S_SHIFT: accept_pt = (bit_idx == 3'd7) && !HAS_GAP;
      S_GAP:   accept_pt = (gap_cnt == GAP_LAST);
      default: accept_pt = 1'b0;
    endcase
  end

  // Round-robin search upward from last_grant+1, wrapping modulo NREQ; first hit wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pick_data = req_data[{pick, 3'b000} +: 8];
  assign take      = accept_pt && en && found && !reset;
  assign req_ready = take ? (NREQ'(1) << pick) : '0;
  assign nxt_idx   = bit_idx + 3'd1;

  // Frame FSM: capture on accept, shift LSB-first, optional gap, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= IDW'(NREQ - 1);
      ser_byte   <= 8'h00;
      grant_id   <= '0;
      bit_idx    <= 3'd0;
      gap_cnt    <= 4'd0;
      ser_out    <= 1'b0;
      ser_frame  <= 1'b0;
      ser_sof    <= 1'b0;
      busy       <= 1'b0;
    end else if (take) begin
      state      <= S_SHIFT;
      ser_byte   <= pick_data;
      grant_id   <= pick;
      last_grant <= pick;
      bit_idx    <= 3'd0;
      ser_out    <= pick_data[0];
      ser_frame  <= 1'b1;
      ser_sof    <= 1'b1;
      busy       <= 1'b1;
    end else if (accept_pt) begin
      // Nothing to take (or en low): park in IDLE; ser_byte/grant_id/bit_idx hold.
      state      <= S_IDLE;
      ser_out    <= 1'b0;
      ser_frame  <= 1'b0;
      ser_sof    <= 1'b0;
      busy       <= 1'b0;
    end else if (state == S_SHIFT) begin
      ser_sof <= 1'b0;
      if (bit_idx != 3'd7) begin
        bit_idx <= nxt_idx;
        ser_out <= ser_byte[nxt_idx];
      end else begin
        // Only reachable with a non-zero gap; the no-gap bit-7 clock is an accept point.
        state     <= S_GAP;
        gap_cnt   <= 4'd0;
        ser_out   <= 1'b0;
        ser_frame <= 1'b0;
        busy      <= 1'b1;
      end
    end else if (state == S_GAP) begin
      gap_cnt <= gap_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_ser_byte_scheduler.sv
// Directed bench for ser_byte_scheduler: per-clock vector table plus multi-cycle sequences.
// Inputs are driven 1ns after posedge, outputs sampled on the following negedge.
// One instance runs with GAP=0, a second with GAP=3 for the inter-frame gap scenario.
module tb_ser_byte_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [3:0]  req_valid = 4'b0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic        ser_out, ser_frame, ser_sof, busy;
  logic [2:0]  bit_idx;
  logic [7:0]  ser_byte;
  logic [1:0]  grant_id;

  logic        en_g = 1'b1;
  logic [3:0]  rv_g = 4'b0;
  logic [31:0] rd_g = 32'h0;
  logic [3:0]  ready_g;
  logic        out_g, frame_g, sof_g, busy_g;
  logic [2:0]  idx_g;
  logic [7:0]  byte_g;
  logic [1:0]  gid_g;

  ser_byte_scheduler #(.NREQ(4), .GAP(0), .IDW(2)) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_out(ser_out), .ser_frame(ser_frame), .ser_sof(ser_sof),
    .bit_idx(bit_idx), .ser_byte(ser_byte), .grant_id(grant_id), .busy(busy)
  );

  ser_byte_scheduler #(.NREQ(4), .GAP(3), .IDW(2)) dut_g (
    .clk(clk), .reset(reset), .en(en_g), .req_valid(rv_g), .req_data(rd_g),
    .req_ready(ready_g), .ser_out(out_g), .ser_frame(frame_g), .ser_sof(sof_g),
    .bit_idx(idx_g), .ser_byte(byte_g), .grant_id(gid_g), .busy(busy_g)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [3:0]  rdy;
    logic        frame;
    logic        sof;
    logic        out;
    logic [2:0]  idx;
    logic        busy;
    logic [1:0]  gid;
    logic [7:0]  sbyte;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic e, input logic [3:0] v,
                              input logic [31:0] d, input logic [3:0] r, input logic f,
                              input logic s, input logic o, input logic [2:0] ix,
                              input logic b, input logic [1:0] g, input logic [7:0] sb);
    vec_t t;
    t.rst = rst; t.en = e; t.vld = v; t.dat = d; t.rdy = r; t.frame = f;
    t.sof = s; t.out = o; t.idx = ix; t.busy = b; t.gid = g; t.sbyte = sb;
    return t;
  endfunction

  // Expected byte of requester g in the all-valid patterns: 0x10, 0x21, 0x32, 0x43.
  function automatic logic [7:0] rr_byte(input logic [1:0] g);
    return 8'h10 + 8'h11 * {6'd0, g};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 4'b0; rv_g = 4'b0; en = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] DA = 32'h0000_00A5;
  localparam logic [31:0] DR = 32'h4332_2110;

  vec_t tbl[14];
  logic [1:0] gq[$];
  logic [7:0] bq[$];
  int sofc[$];

  initial begin
    logic [1:0] exp_g[6];
    int dropped, drop_pending, rdy1_after, bad21, idle_cnt, chg_bad, hit, gap_cnt, idle_g, rdy_cnt, out_bad;
    logic [7:0] prev_byte;

    // Single byte 0xA5, then en low with all valid, then en rising accepts requester 1.
    tbl[0]  = mk(1, 1, 4'h0, 32'h0, 4'h0, 0, 0, 0, 3'd0, 0, 2'd0, 8'h00);
    tbl[1]  = mk(0, 1, 4'h1, DA,    4'h1, 0, 0, 0, 3'd0, 0, 2'd0, 8'h00);
    tbl[2]  = mk(0, 1, 4'h0, DA,    4'h0, 1, 1, 1, 3'd0, 1, 2'd0, 8'hA5);
    tbl[3]  = mk(0, 1, 4'h0, DA,    4'h0, 1, 0, 0, 3'd1, 1, 2'd0, 8'hA5);
    tbl[4]  = mk(0, 1, 4'h0, DA,    4'h0, 1, 0, 1, 3'd2, 1, 2'd0, 8'hA5);
    tbl[5]  = mk(0, 1, 4'h0, DA,    4'h0, 1, 0, 0, 3'd3, 1, 2'd0, 8'hA5);
    tbl[6]  = mk(0, 1, 4'h0, DA,    4'h0, 1, 0, 0, 3'd4, 1, 2'd0, 8'hA5);
    tbl[7]  = mk(0, 1, 4'h0, DA,    4'h0, 1, 0, 1, 3'd5, 1, 2'd0, 8'hA5);
    tbl[8]  = mk(0, 1, 4'h0, DA,    4'h0, 1, 0, 0, 3'd6, 1, 2'd0, 8'hA5);
    tbl[9]  = mk(0, 1, 4'h0, DA,    4'h0, 1, 0, 1, 3'd7, 1, 2'd0, 8'hA5);
    tbl[10] = mk(0, 1, 4'h0, DA,    4'h0, 0, 0, 0, 3'd7, 0, 2'd0, 8'hA5);
    tbl[11] = mk(0, 0, 4'hF, DR,    4'h0, 0, 0, 0, 3'd7, 0, 2'd0, 8'hA5);
    tbl[12] = mk(0, 0, 4'hF, DR,    4'h0, 0, 0, 0, 3'd7, 0, 2'd0, 8'hA5);
    tbl[13] = mk(0, 1, 4'hF, DR,    4'h2, 0, 0, 0, 3'd7, 0, 2'd0, 8'hA5);

    repeat (3) @(posedge clk);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      reset = tbl[i].rst; en = tbl[i].en; req_valid = tbl[i].vld; req_data = tbl[i].dat;
      @(negedge clk);
      check($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      check($sformatf("row%0d_frame", i), 32'(ser_frame), 32'(tbl[i].frame));
      check($sformatf("row%0d_sof", i),   32'(ser_sof),   32'(tbl[i].sof));
      check($sformatf("row%0d_out", i),   32'(ser_out),   32'(tbl[i].out));
      check($sformatf("row%0d_idx", i),   32'(bit_idx),   32'(tbl[i].idx));
      check($sformatf("row%0d_busy", i),  32'(busy),      32'(tbl[i].busy));
      check($sformatf("row%0d_gid", i),   32'(grant_id),  32'(tbl[i].gid));
      check($sformatf("row%0d_byte", i),  32'(ser_byte),  32'(tbl[i].sbyte));
    end

    // Withdrawal: requester 1 drops valid during requester 2's frame and is skipped.
    exp_g = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    gq.delete(); bq.delete();
    dropped = 0; drop_pending = 0; rdy1_after = 0;
    for (int c = 1; c <= 48; c++) begin
      @(posedge clk); #1;
      if (drop_pending != 0) begin req_valid = 4'b1101; dropped = 1; drop_pending = 0; end
      @(negedge clk);
      if (dropped != 0 && req_ready[1]) rdy1_after++;
      if (ser_sof) begin
        gq.push_back(grant_id); bq.push_back(ser_byte);
        if (grant_id == 2'd2 && dropped == 0) drop_pending = 1;
      end
    end
    check("wd_nsof", 32'(gq.size()), 32'd6);
    bad21 = 0;
    for (int i = 0; i < 6 && i < gq.size(); i++) begin
      check($sformatf("wd_grant%0d", i), 32'(gq[i]), 32'(exp_g[i]));
      check($sformatf("wd_byte%0d", i), 32'(bq[i]), 32'(rr_byte(exp_g[i])));
      if (i > 0 && bq[i] == 8'h21) bad21++;
    end
    check("wd_ready1_after_drop", 32'(rdy1_after), 32'd0);
    check("wd_req1_byte_after_drop", 32'(bad21), 32'd0);

    // Round-robin with GAP=0: grants 0,1,2,3,0 back-to-back, ser_byte changes only on sof.
    do_reset();
    reset = 1'b0; req_valid = 4'hF; req_data = DR;
    @(negedge clk);
    check("rr_first_ready", 32'(req_ready), 32'h1);
    gq.delete(); idle_cnt = 0; chg_bad = 0; prev_byte = ser_byte;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!ser_frame) idle_cnt++;
      if (ser_byte != prev_byte && !ser_sof) chg_bad++;
      if (ser_sof) begin
        gq.push_back(grant_id);
        if (ser_byte != rr_byte(grant_id) || ser_byte == prev_byte) chg_bad++;
      end
      prev_byte = ser_byte;
    end
    check("rr_nsof", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      check($sformatf("rr_grant%0d", i), 32'(gq[i]), 32'(i % 4));
    check("rr_idle_clocks", 32'(idle_cnt), 32'd0);
    check("rr_byte_change", 32'(chg_bad), 32'd0);

    // Reset at bit 4 of 0xFF, with valid high in the reset clock; requester 0 first after.
    do_reset();
    reset = 1'b0; req_valid = 4'b0001; req_data = 32'h0000_00FF;
    @(negedge clk);
    check("rst_accept_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0;
    @(negedge clk);
    hit = 0;
    for (int c = 0; c < 12 && hit == 0; c++) begin
      if (bit_idx == 3'd4 && ser_frame) hit = 1;
      else begin @(posedge clk); #1; @(negedge clk); end
    end
    check("rst_reached_bit4", 32'(hit), 32'd1);
    check("rst_bit4_out", 32'(ser_out), 32'd1);
    reset = 1'b1; req_valid = 4'hF; req_data = DR;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready_in_reset", 32'(req_ready), 32'h0);
    check("rst_out", 32'(ser_out), 32'd0);
    check("rst_frame", 32'(ser_frame), 32'd0);
    check("rst_idx", 32'(bit_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_byte", 32'(ser_byte), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_priority0", 32'(req_ready), 32'h1);

    // GAP=3 instance: requester 2 continuously valid, SOF every 11 clocks.
    do_reset();
    reset = 1'b0; req_valid = 4'b0; rv_g = 4'b0100; rd_g = 32'h005A_0000;
    @(negedge clk);
    check("gap_first_ready", 32'(ready_g), 32'h4);
    sofc.delete(); gap_cnt = 0; idle_g = 0; rdy_cnt = 0; out_bad = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (sof_g) begin
        sofc.push_back(c);
        check($sformatf("gap_gid_c%0d", c), 32'(gid_g), 32'd2);
        check($sformatf("gap_byte_c%0d", c), 32'(byte_g), 32'h5A);
      end
      if (!frame_g && busy_g) gap_cnt++;
      if (!busy_g) idle_g++;
      if (ready_g != 4'b0) rdy_cnt++;
      if (!frame_g && out_g) out_bad++;
    end
    check("gap_nsof", 32'(sofc.size()), 32'd3);
    for (int i = 1; i < sofc.size(); i++)
      check($sformatf("gap_spacing%0d", i), 32'(sofc[i] - sofc[i-1]), 32'd11);
    check("gap_clocks", 32'(gap_cnt), 32'd6);
    check("gap_idle_clocks", 32'(idle_g), 32'd0);
    check("gap_ready_count", 32'(rdy_cnt), 32'd2);
    check("gap_out_zero", 32'(out_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
